// File: rtl/cordic_fsm_pkg.sv
// Shared state encoding and variable-counter codes for the CORDIC control FSM.
package cordic_fsm_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned VAR_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 4'd0,
    LOAD      = 4'd1,
    MUX       = 4'd2,
    SHIFT     = 4'd3,
    ADD_BEG   = 4'd4,
    ADD_WAIT  = 4'd5,
    ADD_STORE = 4'd6,
    ITER_CHK  = 4'd7,
    OUT_A     = 4'd8,
    OUT_B     = 4'd9,
    DONE      = 4'd10
  } state_t;

  localparam logic [VAR_W-1:0] VAR_X = 2'd0;
  localparam logic [VAR_W-1:0] VAR_Y = 2'd1;
  localparam logic [VAR_W-1:0] VAR_Z = 2'd2;

endpackage

// File: rtl/cordic_fsm.sv
// Control FSM for the iterative floating-point CORDIC sine/cosine unit.
// Outputs are decodes of the current state; enab_cont_var/enab_cont_iter/load_cont_var are partly Mealy.
module cordic_fsm
  import cordic_fsm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             beg_FSM_CORDIC,
  input  logic             ACK_FSM_CORDIC,
  input  logic             operation,
  input  logic [1:0]       shift_region_flag,
  input  logic [VAR_W-1:0] cont_var,
  input  logic             ready_add_subt,
  input  logic             max_tick_iter,
  input  logic             min_tick_iter,
  input  logic             max_tick_var,
  input  logic             min_tick_var,
  output logic             ready_CORDIC,
  output logic             beg_add_subt,
  output logic             ack_add_subt,
  output logic             sel_mux_1,
  output logic [1:0]       sel_mux_2,
  output logic             sel_mux_3,
  output logic             mode,
  output logic             enab_cont_iter,
  output logic             load_cont_iter,
  output logic             enab_cont_var,
  output logic             load_cont_var,
  output logic             enab_RB1,
  output logic             enab_RB2,
  output logic             enab_d_ff_Xn,
  output logic             enab_d_ff_Yn,
  output logic             enab_d_ff_Zn,
  output logic             enab_dff5,
  output logic             enab_d_ff_out,
  output logic             enab_dff_shifted_x,
  output logic             enab_dff_shifted_y,
  output logic             enab_dff_LUT,
  output logic             enab_dff_sign
);

  state_t state_q, state_d;
  logic   unused_min_tick_var;

  assign unused_min_tick_var = min_tick_var;
  assign mode = 1'b0;

  // Quadrants 2 and 3 swap the roles of X and Y; gated so reset forces it low too.
  assign sel_mux_3 = reset & (operation ^ ((shift_region_flag == 2'b01) ||
                                           (shift_region_flag == 2'b10)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    ready_CORDIC       = 1'b0;
    beg_add_subt       = 1'b0;
    ack_add_subt       = 1'b0;
    sel_mux_1          = 1'b0;
    sel_mux_2          = 2'b00;
    enab_cont_iter     = 1'b0;
    load_cont_iter     = 1'b0;
    enab_cont_var      = 1'b0;
    load_cont_var      = 1'b0;
    enab_RB1           = 1'b0;
    enab_RB2           = 1'b0;
    enab_d_ff_Xn       = 1'b0;
    enab_d_ff_Yn       = 1'b0;
    enab_d_ff_Zn       = 1'b0;
    enab_dff5          = 1'b0;
    enab_d_ff_out      = 1'b0;
    enab_dff_shifted_x = 1'b0;
    enab_dff_shifted_y = 1'b0;
    enab_dff_LUT       = 1'b0;
    enab_dff_sign      = 1'b0;

    unique case (state_q)
      IDLE: if (beg_FSM_CORDIC) state_d = LOAD;
      LOAD: begin
        enab_RB1       = 1'b1;
        load_cont_iter = 1'b1;
        load_cont_var  = 1'b1;
        state_d        = MUX;
      end
      MUX: begin
        enab_RB2  = 1'b1;
        sel_mux_1 = ~min_tick_iter;
        state_d   = SHIFT;
      end
      SHIFT: begin
        enab_dff_shifted_x = 1'b1;
        enab_dff_shifted_y = 1'b1;
        enab_dff_LUT       = 1'b1;
        enab_dff_sign      = 1'b1;
        sel_mux_1          = ~min_tick_iter;
        state_d            = ADD_BEG;
      end
      ADD_BEG: begin
        beg_add_subt = 1'b1;
        sel_mux_2    = cont_var;
        state_d      = ADD_WAIT;
      end
      ADD_WAIT: begin
        sel_mux_2 = cont_var;
        if (ready_add_subt) state_d = ADD_STORE;
      end
      ADD_STORE: begin
        ack_add_subt = 1'b1;
        sel_mux_2    = cont_var;
        unique case (cont_var)
          VAR_X:   enab_d_ff_Xn = 1'b1;
          VAR_Y:   enab_d_ff_Yn = 1'b1;
          VAR_Z:   enab_d_ff_Zn = 1'b1;
          default: ;
        endcase
        if (max_tick_var) begin
          state_d = ITER_CHK;
        end else begin
          enab_cont_var = 1'b1;
          state_d       = ADD_BEG;
        end
      end
      ITER_CHK: begin
        if (max_tick_iter) begin
          state_d = OUT_A;
        end else begin
          enab_cont_iter = 1'b1;
          load_cont_var  = 1'b1;
          state_d        = MUX;
        end
      end
      OUT_A: begin
        enab_dff5 = 1'b1;
        state_d   = OUT_B;
      end
      OUT_B: begin
        enab_d_ff_out = 1'b1;
        state_d       = DONE;
      end
      DONE: begin
        ready_CORDIC = 1'b1;
        if (ACK_FSM_CORDIC) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cordic_fsm.sv
// Directed bench for cordic_fsm: walks the full sequence and compares every output as one vector.
module tb_cordic_fsm;

  logic       clk;
  logic       reset;
  logic       beg_FSM_CORDIC, ACK_FSM_CORDIC, operation;
  logic [1:0] shift_region_flag, cont_var;
  logic       ready_add_subt, max_tick_iter, min_tick_iter, max_tick_var, min_tick_var;
  logic       ready_CORDIC, beg_add_subt, ack_add_subt, sel_mux_1, sel_mux_3, mode;
  logic [1:0] sel_mux_2;
  logic       enab_cont_iter, load_cont_iter, enab_cont_var, load_cont_var;
  logic       enab_RB1, enab_RB2, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn;
  logic       enab_dff5, enab_d_ff_out, enab_dff_shifted_x, enab_dff_shifted_y;
  logic       enab_dff_LUT, enab_dff_sign;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [22:0] B_RDY  = 23'h1 << 22;
  localparam logic [22:0] B_BEG  = 23'h1 << 21;
  localparam logic [22:0] B_ACK  = 23'h1 << 20;
  localparam logic [22:0] B_SEL1 = 23'h1 << 19;
  localparam logic [22:0] S2_Y   = 23'h1 << 17;
  localparam logic [22:0] S2_Z   = 23'h2 << 17;
  localparam logic [22:0] B_SEL3 = 23'h1 << 16;
  localparam logic [22:0] B_ECI  = 23'h1 << 14;
  localparam logic [22:0] B_LCI  = 23'h1 << 13;
  localparam logic [22:0] B_ECV  = 23'h1 << 12;
  localparam logic [22:0] B_LCV  = 23'h1 << 11;
  localparam logic [22:0] B_RB1  = 23'h1 << 10;
  localparam logic [22:0] B_RB2  = 23'h1 << 9;
  localparam logic [22:0] B_XN   = 23'h1 << 8;
  localparam logic [22:0] B_YN   = 23'h1 << 7;
  localparam logic [22:0] B_ZN   = 23'h1 << 6;
  localparam logic [22:0] B_DFF5 = 23'h1 << 5;
  localparam logic [22:0] B_OUT  = 23'h1 << 4;
  localparam logic [22:0] B_SHF  = 23'hF;

  logic [22:0] outs;
  assign outs = {ready_CORDIC, beg_add_subt, ack_add_subt, sel_mux_1, sel_mux_2, sel_mux_3,
                 mode, enab_cont_iter, load_cont_iter, enab_cont_var, load_cont_var,
                 enab_RB1, enab_RB2, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn, enab_dff5,
                 enab_d_ff_out, enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT,
                 enab_dff_sign};

  cordic_fsm dut (
    .clk(clk), .reset(reset), .beg_FSM_CORDIC(beg_FSM_CORDIC), .ACK_FSM_CORDIC(ACK_FSM_CORDIC),
    .operation(operation), .shift_region_flag(shift_region_flag), .cont_var(cont_var),
    .ready_add_subt(ready_add_subt), .max_tick_iter(max_tick_iter), .min_tick_iter(min_tick_iter),
    .max_tick_var(max_tick_var), .min_tick_var(min_tick_var), .ready_CORDIC(ready_CORDIC),
    .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt), .sel_mux_1(sel_mux_1),
    .sel_mux_2(sel_mux_2), .sel_mux_3(sel_mux_3), .mode(mode), .enab_cont_iter(enab_cont_iter),
    .load_cont_iter(load_cont_iter), .enab_cont_var(enab_cont_var), .load_cont_var(load_cont_var),
    .enab_RB1(enab_RB1), .enab_RB2(enab_RB2), .enab_d_ff_Xn(enab_d_ff_Xn),
    .enab_d_ff_Yn(enab_d_ff_Yn), .enab_d_ff_Zn(enab_d_ff_Zn), .enab_dff5(enab_dff5),
    .enab_d_ff_out(enab_d_ff_out), .enab_dff_shifted_x(enab_dff_shifted_x),
    .enab_dff_shifted_y(enab_dff_shifted_y), .enab_dff_LUT(enab_dff_LUT),
    .enab_dff_sign(enab_dff_sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; beg_FSM_CORDIC = 1'b1; ACK_FSM_CORDIC = 1'b0; operation = 1'b0;
    shift_region_flag = 2'b00; cont_var = 2'd0; ready_add_subt = 1'b0;
    max_tick_iter = 1'b0; min_tick_iter = 1'b1; max_tick_var = 1'b0; min_tick_var = 1'b0;

    repeat (3) tick();
    check("reset_outs", 32'(outs), 32'(23'h0));

    reset = 1'b1; beg_FSM_CORDIC = 1'b0;
    tick();
    check("idle_outs", 32'(outs), 32'(23'h0));

    operation = 1'b1; shift_region_flag = 2'b01; #1;
    check("sel3_op1_f01", 32'(sel_mux_3), 32'd0);
    operation = 1'b0; shift_region_flag = 2'b00; #1;
    check("sel3_op0_f00", 32'(sel_mux_3), 32'd0);
    operation = 1'b1; shift_region_flag = 2'b00; #1;
    check("sel3_op1_f00", 32'(sel_mux_3), 32'd1);
    operation = 1'b0; shift_region_flag = 2'b10; #1;
    check("sel3_op0_f10", 32'(sel_mux_3), 32'd1);
    shift_region_flag = 2'b00;

    // First iteration: load, mux, shift, then one adder transaction on Y.
    beg_FSM_CORDIC = 1'b1;
    tick(); beg_FSM_CORDIC = 1'b0;
    check("load", 32'(outs), 32'(B_RB1 | B_LCI | B_LCV));
    tick();
    check("mux_first", 32'(outs), 32'(B_RB2));
    tick();
    check("shift_first", 32'(outs), 32'(B_SHF));
    cont_var = 2'd1; ready_add_subt = 1'b1;
    tick();
    check("add_beg_y", 32'(outs), 32'(B_BEG | S2_Y));
    tick(); ready_add_subt = 1'b0;
    check("add_wait_y", 32'(outs), 32'(S2_Y));
    for (int i = 0; i < 8; i++) begin
      tick();
      check("wait_no_ack", 32'(outs), 32'(S2_Y));
    end
    ready_add_subt = 1'b1;
    tick(); ready_add_subt = 1'b0;
    check("store_y", 32'(outs), 32'(B_ACK | S2_Y | B_YN | B_ECV));

    // Last variable of the iteration, with an early consumer ACK that must be dropped.
    cont_var = 2'd2;
    tick();
    check("add_beg_z", 32'(outs), 32'(B_BEG | S2_Z));
    ready_add_subt = 1'b1; max_tick_var = 1'b1;
    tick();
    check("add_wait_z", 32'(outs), 32'(S2_Z));
    tick(); ready_add_subt = 1'b0; min_tick_iter = 1'b0; ACK_FSM_CORDIC = 1'b1;
    check("store_z_last", 32'(outs), 32'(B_ACK | S2_Z | B_ZN));
    tick(); ACK_FSM_CORDIC = 1'b0;
    check("iter_chk_next", 32'(outs), 32'(B_ECI | B_LCV));
    tick();
    check("mux_fedback", 32'(outs), 32'(B_RB2 | B_SEL1));
    tick();
    check("shift_fedback", 32'(outs), 32'(B_SHF | B_SEL1));

    // Final iteration on X; a stray start request is ignored.
    cont_var = 2'd0; beg_FSM_CORDIC = 1'b1; ready_add_subt = 1'b1;
    tick();
    check("add_beg_x", 32'(outs), 32'(B_BEG));
    tick();
    check("add_wait_x", 32'(outs), 32'(23'h0));
    tick(); ready_add_subt = 1'b0; beg_FSM_CORDIC = 1'b0; max_tick_iter = 1'b1;
    check("store_x_last", 32'(outs), 32'(B_ACK | B_XN));
    tick();
    check("iter_chk_done", 32'(outs), 32'(23'h0));
    tick();
    check("out_a", 32'(outs), 32'(B_DFF5));
    tick();
    check("out_b", 32'(outs), 32'(B_OUT));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("done_hold", 32'(outs), 32'(B_RDY));
    end
    ACK_FSM_CORDIC = 1'b1;
    tick(); ACK_FSM_CORDIC = 1'b0;
    check("back_idle", 32'(outs), 32'(23'h0));
    tick();
    check("idle_stays", 32'(outs), 32'(23'h0));

    // Abort from ADD_WAIT with asynchronous reset.
    max_tick_iter = 1'b0; max_tick_var = 1'b0; min_tick_iter = 1'b1;
    operation = 1'b1; cont_var = 2'd1; beg_FSM_CORDIC = 1'b1;
    tick(); beg_FSM_CORDIC = 1'b0;
    repeat (3) tick();
    check("abort_add_beg", 32'(outs), 32'(B_BEG | S2_Y | B_SEL3));
    tick();
    check("abort_add_wait", 32'(outs), 32'(S2_Y | B_SEL3));
    #2 reset = 1'b0; #1;
    check("abort_async", 32'(outs), 32'(23'h0));
    tick();
    check("abort_held", 32'(outs), 32'(23'h0));
    reset = 1'b1; operation = 1'b0;
    tick();
    check("abort_idle", 32'(outs), 32'(23'h0));
    check("mode_zero", 32'(mode), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
